uart_rx_buffered: RTL and testbench

- 8N1 UART receiver with 16x oversampling, start-bit validation, framing-error detection and a receive FIFO with a read handshake.
- Sits beside the transmitter on the link's receive side. It hands bytes to the host through a first-word-fall-through buffer rather than a single unbuffered dout register.
- Rx timing comes from an external oversample strobe, rxclken, produced by the shared baud generator.

---
 rtl/uart_rx_buffered.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver (16x oversampled by rxclken) feeding a first-word-fall-through FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_buffered #(
  parameter int DEPTH       = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     rxclk,
  input  logic                     rst,
  input  logic                     rxclken,
  input  logic                     rx,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [SYNC_STAGES-1:0] rx_sync_p0;
  logic                   rx_s;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   at_mid;
  logic                   at_end;
  logic                   stop_smp;
  logic                   good_byte;
  logic                   push;
  logic                   pop;
  logic                   drop;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
`endif

  // Synchronizer stage: runs every rxclk, not just on ticks
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) rx_sync_p0 <= '1;
    else     rx_sync_p0 <= {rx_sync_p0[SYNC_STAGES-2:0], rx};
  end

  assign rx_s     = rx_sync_p0[SYNC_STAGES-1];
  assign at_mid   = (cnt == CNT_MID);
  assign at_end   = (cnt == CNT_END);
  assign stop_smp = rxclken && (state == STOP) && at_end;
  assign pop      = rd_en && !empty;
`ifdef UART_RX_PARITY_EN
  assign good_byte = stop_smp && rx_s && !par_bad;
`else
  assign good_byte = stop_smp && rx_s;
`endif
  // A pop in the stop-sample cycle frees the slot, so full alone does not drop
  assign push = good_byte && (!full || pop);
  assign drop = good_byte && full && !pop;

  // Framing stage: bit-level FSM and registered error pulses
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= stop_smp && !rx_s;
      overrun   <= drop;
`ifdef UART_RX_PARITY_EN
      parity_err <= stop_smp && rx_s && par_bad;
`endif
      if (rxclken) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (at_mid) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (at_end) begin
              cnt     <= '0;
              shreg   <= {rx_s, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (at_end) begin
              cnt     <= '0;
              par_bad <= (rx_s != ^shreg);
              state   <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`endif
          STOP: begin
            if (at_end) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Buffer stage: FWFT storage, pointers wrap modulo DEPTH
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered (OVERSAMPLE=16, DEPTH=8); parity steps run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_buffered;

  logic       rxclk = 1'b0;
  logic       rst;
  logic       rxclken;
  logic       rx;
  logic       rd_en;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         par_flip = 0;
  int         pe_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;
  int div = 1;
  int phase = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;

  uart_rx_buffered #(.DEPTH(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .rxclk(rxclk),
    .rst(rst),
    .rxclken(rxclken),
    .rx(rx),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count),
    .frame_err(frame_err),
    .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 rxclk = ~rxclk;

  initial begin
    rxclken = 1'b1;
    forever begin
      @(negedge rxclk);
      if (div <= 1) begin
        rxclken = 1'b1;
      end else begin
        rxclken = (phase == 0);
        phase   = (phase + 1) % div;
      end
    end
  end

  always @(negedge rxclk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start bit plus eight data bits, LSB first; called on a negedge with the line idle.
  task automatic send_bits(input logic [7:0] d);
    rx = 1'b0;
    repeat (16*div) @(negedge rxclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16*div) @(negedge rxclk);
    end
  endtask

  // Returns on the negedge just before the stop-sample edge (rxclken tied high).
  task automatic to_stop(input logic [7:0] d, input logic stopb);
    send_bits(d);
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip[0];
    repeat (16) @(negedge rxclk);
`endif
    rx = stopb;
    repeat (10) @(negedge rxclk);
  endtask

  task automatic finish_frame();
    repeat (5) @(negedge rxclk);
    rx = 1'b1;
    repeat (20) @(negedge rxclk);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d);
`ifdef UART_RX_PARITY_EN
    rx = ^d;
    repeat (16*div) @(negedge rxclk);
`endif
    rx = 1'b1;
    repeat (16*div) @(negedge rxclk);
    repeat (8*div) @(negedge rxclk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge rxclk);
    rd_en = 1'b0;
  endtask

  task automatic reset_mid_frame(input string tag);
    send_frame(8'h42);
    chk({tag, "_pre_count"}, 32'(count), 32'd1);
    rx = 1'b0;
    repeat (16*div) @(negedge rxclk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (16*div) @(negedge rxclk);
    end
    rx = 1'b1;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_count"}, 32'(count), 32'd0);
    chk({tag, "_rst_empty"}, 32'(empty), 32'd1);
    chk({tag, "_rst_full"}, 32'(full), 32'd0);
    chk({tag, "_rst_dout"}, 32'(dout), 32'h00);
    chk({tag, "_rst_flags"}, {30'd0, frame_err, overrun}, 32'd0);
    repeat (2) @(negedge rxclk);
    rst = 1'b0;
    repeat (20*div) @(negedge rxclk);
    send_frame(8'h81);
    chk({tag, "_next_count"}, 32'(count), 32'd1);
    chk({tag, "_next_dout"}, 32'(dout), 32'h81);
    pop_one();
    chk({tag, "_next_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge rxclk);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_flags", {30'd0, frame_err, overrun}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge rxclk);

    // single byte
    to_stop(8'hA5, 1'b1);
    chk("a5_empty_before", 32'(empty), 32'd1);
    @(negedge rxclk);
    chk("a5_empty_after", 32'(empty), 32'd0);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_count", 32'(count), 32'd1);
    chk("a5_flags", {30'd0, frame_err, overrun}, 32'd0);
    finish_frame();
    pop_one();
    chk("a5_pop_empty", 32'(empty), 32'd1);
    chk("a5_pop_count", 32'(count), 32'd0);

    // false start then framing error
    rx = 1'b0;
    repeat (4) @(negedge rxclk);
    rx = 1'b1;
    repeat (30) @(negedge rxclk);
    chk("false_start_count", 32'(count), 32'd0);
    chk("false_start_fe", 32'(fe_cnt), 32'd0);
    to_stop(8'h3C, 1'b0);
    @(negedge rxclk);
    chk("fe_pulse", 32'(frame_err), 32'd1);
    chk("fe_count", 32'(count), 32'd0);
    @(negedge rxclk);
    chk("fe_pulse_end", 32'(frame_err), 32'd0);
    finish_frame();
    chk("fe_total", 32'(fe_cnt), 32'd1);
    chk("fe_empty", 32'(empty), 32'd1);

    // overrun
    for (int b = 0; b < 8; b++) send_frame(8'(b));
    chk("ovr_full", 32'(full), 32'd1);
    chk("ovr_count", 32'(count), 32'd8);
    to_stop(8'h08, 1'b1);
    @(negedge rxclk);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_count_after", 32'(count), 32'd8);
    @(negedge rxclk);
    chk("ovr_pulse_end", 32'(overrun), 32'd0);
    finish_frame();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovr_read%0d", i), 32'(dout), 32'(i));
      pop_one();
    end
    chk("ovr_drain_empty", 32'(empty), 32'd1);
    chk("ovr_total", 32'(ov_cnt), 32'd1);

    // simultaneous push and pop at full
    for (int b = 0; b < 8; b++) send_frame(8'h10 + 8'(b));
    chk("sim_full", 32'(full), 32'd1);
    to_stop(8'h55, 1'b1);
    rd_en = 1'b1;
    @(negedge rxclk);
    rd_en = 1'b0;
    chk("sim_no_overrun", 32'(overrun), 32'd0);
    chk("sim_count", 32'(count), 32'd8);
    chk("sim_head", 32'(dout), 32'h11);
    finish_frame();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sim_read%0d", i), 32'(dout), (i == 7) ? 32'h55 : 32'(8'h11 + 8'(i)));
      pop_one();
    end
    chk("sim_drain_empty", 32'(empty), 32'd1);
    chk("sim_ov_total", 32'(ov_cnt), 32'd1);

    // reset mid-frame, full-rate then quarter-rate oversample strobe
    reset_mid_frame("rst_div1");
    div = 4;
    repeat (8) @(negedge rxclk);
    reset_mid_frame("rst_div4");
    div = 1;
    repeat (8) @(negedge rxclk);

`ifdef UART_RX_PARITY_EN
    par_flip = 0;
    to_stop(8'h07, 1'b1);
    @(negedge rxclk);
    chk("par_ok_count", 32'(count), 32'd1);
    chk("par_ok_perr", 32'(parity_err), 32'd0);
    finish_frame();
    pop_one();
    par_flip = 1;
    to_stop(8'h07, 1'b1);
    @(negedge rxclk);
    chk("par_bad_perr", 32'(parity_err), 32'd1);
    chk("par_bad_count", 32'(count), 32'd0);
    @(negedge rxclk);
    chk("par_bad_perr_end", 32'(parity_err), 32'd0);
    finish_frame();
    par_flip = 0;
    chk("par_total", 32'(pe_cnt), 32'd1);
`endif

    chk("fe_total_end", 32'(fe_cnt), 32'd1);
    chk("no_coincident_flags", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
